// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types, constants and helpers for the ADC scan controller
package adc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP
    } adc_state_e;

    localparam int CTRL_BITS   = 8;
    localparam int READ_BITS   = 16;
    localparam int FRAME_SCLKS = 24;

    function automatic logic [7:0] ctrl_byte(input logic [2:0] sel, input logic [3:0] lsb);
        return {1'b1, sel, lsb};
    endfunction

    // Returns {wrap, channel}: lowest enabled channel above cur, or the lowest enabled one with wrap=1.
    function automatic logic [3:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
        logic       found;
        logic [2:0] ch;
        found = 1'b0;
        ch    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                ch    = i[2:0];
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 7; i >= 0; i--) begin
                if (mask[i]) ch = i[2:0];
            end
        end
        return {~found, ch};
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// rtl/adc_sclk_gen.sv - SCLK divider with rise/fall strobes and rising-edge counter
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic       sclk,
    output logic       rise,
    output logic       fall,
    output logic [4:0] sclk_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             term;

    // Strobes mark the clk edge on which sclk toggles.
    assign term = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise = term && !sclk;
    assign fall = term && sclk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            sclk     <= 1'b0;
            sclk_cnt <= '0;
        end else if (clr) begin
            div_cnt  <= '0;
            sclk     <= 1'b0;
            sclk_cnt <= '0;
        end else if (en) begin
            if (term) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
                if (!sclk && (sclk_cnt != 5'(FRAME_SCLKS))) sclk_cnt <= sclk_cnt + 5'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - masked multi-channel scan controller for a serial SPI ADC
module adc_scan_ctrl
    import adc_pkg::*;
#(
    parameter int          NUM_CH   = 3,
    parameter int          RES_W    = 12,
    parameter int          CLK_DIV  = 4,
    parameter int          CS_GAP   = 2,
    parameter logic [3:0]  CTRL_LSB = 4'b1111
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 single_shot,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic                 busy,
    output logic                 cs_n,
    output logic                 sclk,
    output logic                 din,
    input  logic                 dout,
    output logic [15:0]          sample_data,
    output logic [2:0]           sample_ch,
    output logic                 sample_valid,
    output logic                 scan_done,
    output logic [NUM_CH*16-1:0] adc_values
);

    localparam int TMR_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    adc_state_e        state;
    logic [TMR_W-1:0]  tmr;
    logic [2:0]        ch;
    logic [NUM_CH-1:0] mask_l;
    logic              single_l;
    logic              stop_seen;
    logic [15:0]       capture;
    logic [3:0]        nxt;
    logic [3:0]        first;
    logic [7:0]        ctrl_sh;
    logic [15:0]       res;
    logic              rise;
    logic              fall;
    logic [4:0]        sclk_cnt;
    logic              stop_eff;

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk      (clk),
        .rst      (rst),
        .en       (state == S_SHIFT),
        .clr      (state != S_SHIFT),
        .sclk     (sclk),
        .rise     (rise),
        .fall     (fall),
        .sclk_cnt (sclk_cnt)
    );

    always_comb begin
        nxt      = next_ch(8'(mask_l), ch);
        first    = next_ch(8'(ch_mask), 3'd7);
        // After falling edge k the control bit 7-k is on bit 7; past the byte it shifts to 0.
        ctrl_sh  = ctrl_byte(ch, CTRL_LSB) << sclk_cnt;
        res      = 16'(capture >> (READ_BITS - RES_W));
        stop_eff = stop_seen | stop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            tmr          <= '0;
            ch           <= '0;
            mask_l       <= '0;
            single_l     <= 1'b0;
            stop_seen    <= 1'b0;
            capture      <= '0;
            busy         <= 1'b0;
            cs_n         <= 1'b1;
            din          <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            scan_done    <= 1'b0;
            adc_values   <= '0;
        end else begin
            sample_valid <= 1'b0;
            scan_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    stop_seen <= 1'b0;
                    if (start && !stop && (|ch_mask)) begin
                        mask_l   <= ch_mask;
                        single_l <= single_shot;
                        ch       <= first[2:0];
                        busy     <= 1'b1;
                        cs_n     <= 1'b0;
                        din      <= 1'b1;
                        tmr      <= TMR_W'(CLK_DIV - 1);
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (stop) stop_seen <= 1'b1;
                    if (tmr == '0) state <= S_SHIFT;
                    else           tmr   <= tmr - TMR_W'(1);
                end
                S_SHIFT: begin
                    if (stop) stop_seen <= 1'b1;
                    if (rise && (sclk_cnt >= 5'(CTRL_BITS))) capture <= {capture[14:0], dout};
                    if (fall) begin
                        din <= ctrl_sh[7];
                        if (sclk_cnt == 5'(FRAME_SCLKS)) begin
                            cs_n         <= 1'b1;
                            din          <= 1'b0;
                            sample_valid <= 1'b1;
                            sample_ch    <= ch;
                            sample_data  <= res;
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (ch == 3'(i)) adc_values[16*i +: 16] <= res;
                            end
                            tmr       <= TMR_W'(CS_GAP - 1);
                            scan_done <= nxt[3] && (CS_GAP == 1);
                            state     <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (stop) stop_seen <= 1'b1;
                    // Registered strobe: raise it one cycle early so it lands on the last gap cycle.
                    if (tmr == TMR_W'(1)) scan_done <= nxt[3];
                    if (tmr == '0) begin
                        if (stop_eff || (nxt[3] && single_l)) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            ch    <= nxt[2:0];
                            cs_n  <= 1'b0;
                            din   <= 1'b1;
                            tmr   <= TMR_W'(CLK_DIV - 1);
                            state <= S_SETUP;
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - directed self-checking bench for adc_scan_ctrl
module tb_adc_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        single_shot = 1'b0;
    logic [2:0]  ch_mask = 3'b000;
    logic        dout = 1'b0;

    logic        busy, cs_n, sclk, din, sample_valid, scan_done;
    logic [15:0] sample_data;
    logic [2:0]  sample_ch;
    logic [47:0] adc_values;

    logic        b_busy, b_cs_n, b_sclk, b_din, b_sample_valid, b_scan_done;
    logic [15:0] b_sample_data;
    logic [2:0]  b_sample_ch;
    logic [47:0] b_adc_values;

    logic        c_busy, c_cs_n, c_sclk, c_din, c_sample_valid, c_scan_done;
    logic [15:0] c_sample_data;
    logic [2:0]  c_sample_ch;
    logic [47:0] c_adc_values;

    adc_scan_ctrl #(.NUM_CH(3), .RES_W(12), .CLK_DIV(2), .CS_GAP(2)) u12 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .single_shot(single_shot),
        .ch_mask(ch_mask), .busy(busy), .cs_n(cs_n), .sclk(sclk), .din(din), .dout(dout),
        .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
        .scan_done(scan_done), .adc_values(adc_values)
    );

    adc_scan_ctrl #(.NUM_CH(3), .RES_W(16), .CLK_DIV(2), .CS_GAP(2)) u16 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .single_shot(single_shot),
        .ch_mask(ch_mask), .busy(b_busy), .cs_n(b_cs_n), .sclk(b_sclk), .din(b_din), .dout(dout),
        .sample_data(b_sample_data), .sample_ch(b_sample_ch), .sample_valid(b_sample_valid),
        .scan_done(b_scan_done), .adc_values(b_adc_values)
    );

    adc_scan_ctrl #(.NUM_CH(3), .RES_W(8), .CLK_DIV(2), .CS_GAP(2)) u8 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .single_shot(single_shot),
        .ch_mask(ch_mask), .busy(c_busy), .cs_n(c_cs_n), .sclk(c_sclk), .din(c_din), .dout(dout),
        .sample_data(c_sample_data), .sample_ch(c_sample_ch), .sample_valid(c_sample_valid),
        .scan_done(c_scan_done), .adc_values(c_adc_values)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic [15:0] resp [8];
    logic [7:0]  ctrl_sr = 8'h00;
    logic [7:0]  ctrl_log [$];
    logic [15:0] word = 16'h0000;
    int          rcnt = 0;
    int          fcnt = 0;

    always @(negedge cs_n) begin
        rcnt = 0;
        fcnt = 0;
    end

    always @(posedge sclk) begin
        rcnt = rcnt + 1;
        if (rcnt <= 8) ctrl_sr = {ctrl_sr[6:0], din};
        if (rcnt == 8) ctrl_log.push_back(ctrl_sr);
    end

    always @(negedge sclk) begin
        fcnt = fcnt + 1;
        if (fcnt == 8) word = resp[ctrl_sr[6:4]];
        if (fcnt >= 8 && fcnt <= 23) dout = word[23 - fcnt];
        else                         dout = 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [2:0]  vch [$];
    logic [15:0] vdat [$];
    int          vcyc [$];
    int          ndone, done_cyc, fall_cyc, stop_at, extra, cs_low, busy_hits, idle_cnt, lock_err;
    bit          ended;

    initial begin
        for (int i = 0; i < 8; i++) resp[i] = 16'h0000;

        // Reset values
        tick(3);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_busy", busy, 0);
        check("rst_din", din, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_data", sample_data, 0);
        check("rst_values", adc_values, 0);

        // Reset asserted mid-SHIFT while sclk is high
        rst = 1'b1;
        tick(2);
        single_shot = 1'b1;
        ch_mask = 3'b111;
        resp[0] = 16'hFFF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(40);
        for (int k = 0; k < 8; k++) begin
            if (sclk) break;
            tick();
        end
        check("A_sclk_high_pre", sclk, 1);
        check("A_cs_low_pre", cs_n, 0);
        rst = 1'b0;
        #1;
        check("A_cs_n_async", cs_n, 1);
        check("A_sclk_async", sclk, 0);
        check("A_busy_async", busy, 0);
        tick(2);
        check("A_values_zero", adc_values, 0);
        rst = 1'b1;
        tick(3);

        // Single-shot scan of channels 0 and 2
        resp[0] = 16'hABC0;
        resp[2] = 16'h1230;
        ctrl_log.delete();
        vch.delete();
        vdat.delete();
        ndone = 0; done_cyc = -1; fall_cyc = -1; lock_err = 0;
        single_shot = 1'b1;
        ch_mask = 3'b101;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            tick();
            if ((b_sclk !== sclk) || (c_din !== din) || (b_cs_n !== cs_n) || (c_busy !== busy) ||
                (b_sample_valid !== sample_valid) || (c_scan_done !== scan_done) ||
                (b_sample_ch !== sample_ch) || (c_sample_ch !== sample_ch) ||
                (c_sclk !== sclk) || (b_din !== din) || (c_cs_n !== cs_n) || (b_busy !== busy) ||
                (c_sample_valid !== sample_valid) || (b_scan_done !== scan_done))
                lock_err++;
            if (sample_valid) begin
                vch.push_back(sample_ch);
                vdat.push_back(sample_data);
            end
            if (scan_done) begin
                ndone++;
                done_cyc = c;
            end
            if (!busy) begin
                fall_cyc = c;
                break;
            end
        end
        check("B_terminated", (fall_cyc > 0), 1);
        check("B_frames", vch.size(), 2);
        check("B_ch0", vch[0], 0);
        check("B_ch1", vch[1], 2);
        check("B_data0", vdat[0], 16'h0ABC);
        check("B_data1", vdat[1], 16'h0123);
        check("B_ctrl_count", ctrl_log.size(), 2);
        check("B_ctrl0", ctrl_log[0], 8'h8F);
        check("B_ctrl1", ctrl_log[1], 8'hAF);
        check("B_scan_done_count", ndone, 1);
        check("B_busy_falls_after_done", 64'(fall_cyc - done_cyc), 1);
        check("B_bank_ch0", adc_values[15:0], 16'h0ABC);
        check("B_bank_ch1", adc_values[31:16], 16'h0000);
        check("B_bank_ch2", adc_values[47:32], 16'h0123);
        check("B_bank16_ch0", b_adc_values[15:0], 16'hABC0);
        check("B_bank8_ch2", c_adc_values[47:32], 16'h0012);
        check("B_lockstep", lock_err, 0);

        // Continuous scan, stop during the second ch1 frame
        resp[1] = 16'h5550;
        vch.delete();
        vdat.delete();
        vcyc.delete();
        ndone = 0; stop_at = -1; ended = 1'b0;
        single_shot = 1'b0;
        ch_mask = 3'b111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            tick();
            if (sample_valid) begin
                vch.push_back(sample_ch);
                vdat.push_back(sample_data);
                vcyc.push_back(c);
                if (vch.size() == 4 && stop_at < 0) stop_at = c + 50;
            end
            stop = (c == stop_at);
            if (scan_done) ndone++;
            if (!busy) begin
                ended = 1'b1;
                break;
            end
        end
        stop = 1'b0;
        extra = 0; cs_low = 0;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (sample_valid) extra++;
            if (!cs_n) cs_low++;
        end
        check("C_terminated", ended, 1);
        check("C_frames", vch.size(), 5);
        check("C_seq0", vch[0], 0);
        check("C_seq1", vch[1], 1);
        check("C_seq2", vch[2], 2);
        check("C_seq3", vch[3], 0);
        check("C_seq4", vch[4], 1);
        check("C_period01", 64'(vcyc[1] - vcyc[0]), 100);
        check("C_period23", 64'(vcyc[3] - vcyc[2]), 100);
        check("C_period34", 64'(vcyc[4] - vcyc[3]), 100);
        check("C_last_data", vdat[4], 16'h0555);
        check("C_scan_done_count", ndone, 1);
        check("C_no_frame_after_stop", extra, 0);
        check("C_cs_idle", cs_low, 0);

        // Ignored starts
        busy_hits = 0; cs_low = 0;
        ch_mask = 3'b000;
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (busy) busy_hits++;
            if (!cs_n) cs_low++;
        end
        ch_mask = 3'b111;
        stop = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (busy) busy_hits++;
            if (!cs_n) cs_low++;
        end
        start = 1'b0;
        stop = 1'b0;
        tick();
        check("D_busy_stays_low", busy_hits, 0);
        check("D_cs_stays_high", cs_low, 0);

        // start held through a single-shot scan, mask changed mid-scan
        resp[0] = 16'h4440;
        resp[1] = 16'h7770;
        vch.delete();
        vdat.delete();
        idle_cnt = 0; ended = 1'b0;
        single_shot = 1'b1;
        ch_mask = 3'b001;
        start = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            tick();
            if (c == 20) ch_mask = 3'b010;
            if (sample_valid) begin
                vch.push_back(sample_ch);
                vdat.push_back(sample_data);
            end
            if (vch.size() == 2 && !busy) begin
                ended = 1'b1;
                break;
            end
            if (!busy) idle_cnt++;
            if (idle_cnt > 0 && busy) start = 1'b0;
        end
        start = 1'b0;
        tick();
        check("E_terminated", ended, 1);
        check("E_frames", vch.size(), 2);
        check("E_first_ch", vch[0], 0);
        check("E_second_ch", vch[1], 1);
        check("E_first_data", vdat[0], 16'h0444);
        check("E_second_data", vdat[1], 16'h0777);
        check("E_idle_gap", idle_cnt, 1);
        check("E_idle_after", busy, 0);

        // All-ones readback across resolutions
        resp[1] = 16'hFFFF;
        ended = 1'b0;
        single_shot = 1'b1;
        ch_mask = 3'b010;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (!busy) begin
                ended = 1'b1;
                break;
            end
        end
        check("F_terminated", ended, 1);
        check("F_data12", sample_data, 16'h0FFF);
        check("F_data16", b_sample_data, 16'hFFFF);
        check("F_data8", c_sample_data, 16'h00FF);
        check("F_ch", sample_ch, 1);
        check("F_bank16_ch1", b_adc_values[31:16], 16'hFFFF);
        check("F_bank8_ch1", c_adc_values[31:16], 16'h00FF);
        check("F_bank12_ch0_kept", adc_values[15:0], 16'h0444);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Parametrised successor to the three-channel serial ADC driver.
- Scans a programmable, masked set of up to 8 single-ended channels on a Maxim-style SPI ADC (8-bit control byte, 16-clock readback).
- Supports continuous and single-shot scan modes and a configurable SCLK rate.
- Sits between the Pmod pins and the sample-processing logic; results go to a per-channel register bank, each with a tagged valid strobe.

Parameters:
- NUM_CH, 3: channel count, 1..8; channel i uses SEL = i.
- RES_W, 12: converter resolution, 8..16.
- CLK_DIV, 4: clk cycles per SCLK half-period, >=1.
- CS_GAP, 2: minimum clk cycles cs_n stays high between frames, >=1.
- CTRL_LSB, 4'b1111: low nibble of control byte (UNI/BIP, SGL/DIF, PD1, PD0).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse; begins a scan when idle.
- stop  in  1  ends continuous scanning after the current frame.
- single_shot  in  1  1 = one scan then idle; 0 = continuous.
- ch_mask  in  NUM_CH  channel enable; bit i enables channel i.
- busy  out  1  high from scan start until return to IDLE.
- cs_n  out  1  ADC chip select.
- sclk  out  1  ADC serial clock, idle low.
- din  out  1  control bits to ADC.
- dout  in  1  conversion bits from ADC.
- sample_data  out  16  last result, right-justified, zero-extended.
- sample_ch  out  3  channel of sample_data.
- sample_valid  out  1  one-clk strobe per completed frame.
- scan_done  out  1  one-clk strobe after last enabled channel of a scan.
- adc_values  out  NUM_CH*16  bank; slice [16i+15:16i] = channel i.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; cs_n=1, sclk=0, din=0, busy=0, strobes 0, sample_data/sample_ch/adc_values all 0. Assertion mid-frame aborts immediately; no partial result is written.
- States: IDLE -> SETUP -> SHIFT -> GAP -> (SETUP | IDLE).
- IDLE:
  - start=1, stop=0, ch_mask!=0 -> latch ch_mask and single_shot, select lowest enabled channel, busy=1, go to SETUP.
  - start with stop=1 or ch_mask=0 is ignored; busy stays 0.
- SETUP: cs_n=0, din=control MSB. Stay CLK_DIV cycles, then go to SHIFT.
- SHIFT: 24 SCLK periods, each CLK_DIV low + CLK_DIV high.
  - din changes only on sclk falling edges.
  - Control byte, MSB first: 1, SEL[2:0], CTRL_LSB.
  - dout sampled on rising edges 9..24 into a 16-bit shift register.
  - After the 24th falling edge: result = capture[15 -: RES_W], zero-extended.
  - Same clk: cs_n=1, sample_valid=1, sample_ch=channel, sample_data and adc_values slice updated, go to GAP.
- GAP: cs_n high for CS_GAP cycles. Then advance to the next enabled channel above the current one.
  - If none remains, the scan is complete: scan_done pulses on the last GAP cycle.
  - Scan complete and (latched single_shot=1 or stop seen) -> IDLE with busy=0. Otherwise wrap to the lowest latched channel and go to SETUP.
- stop:
  - Sticky once seen while busy; cleared in IDLE.
  - Never truncates a frame; the current frame completes, then IDLE (scan_done not pulsed if the scan is partial).
- ch_mask changes while busy are ignored until the next scan start.
- Frame length: CLK_DIV + 48*CLK_DIV + CS_GAP clk cycles.

Decomposition:
- Shared package adc_pkg:
  - State enumeration.
  - Constants CTRL_BITS=8, READ_BITS=16, FRAME_SCLKS=24.
  - Function building the control byte from SEL and CTRL_LSB.
  - Function finding the next enabled channel (mask, current) with wrap flag.
- Sub-module adc_sclk_gen:
  - Divider producing sclk plus one-clk rise/fall strobes and a 0..24 edge counter.
  - Enable and clear inputs.

Test Plan:
- Reset mid-SHIFT (NUM_CH=3, CLK_DIV=2) -> cs_n=1 and sclk=0 within the same clk; adc_values stays 0.
- single_shot=1, ch_mask=3'b101, ADC model returns 0xABC0 (ch0) and 0x1230 (ch2), RES_W=12:
  - Exactly two frames; control bytes 0x8F then 0xAF.
  - sample_ch 0 then 2; adc_values ch0=0x0ABC, ch2=0x0123.
  - One scan_done; busy falls after it.
- Continuous, ch_mask=3'b111: frames cycle channels 0,1,2,0,...
  - Frame period 2+96+2=100 clk at CLK_DIV=2, CS_GAP=2.
  - Assert stop mid-frame of ch1 -> ch1 frame completes, sample_valid pulses, then IDLE with no ch2 frame.
- start with ch_mask=0, or start and stop asserted together in IDLE -> busy stays 0; cs_n stays 1.
- start held high during a single-shot scan -> a new scan starts only on return to IDLE; ch_mask changed mid-scan takes effect on the next scan only.
- RES_W=16, dout=1 for all read bits -> sample_data=0xFFFF; RES_W=8 -> 0x00FF.
